// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: bundles the two request channels, the logic-unit
// drive/return signals and the response channel of logic_unit_arbiter.
// Optional feature macro: LU_ZERO_FLAG_EN adds the rsp_zero response bit.
// slave  = the arbiter side, master = the environment (requesters, logic unit,
// response consumer).
`timescale 1ns/1ps
interface logic_unit_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  lu_op;
  logic [31:0] lu_a;
  logic [31:0] lu_b;
  logic [31:0] lu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_err;
`ifdef LU_ZERO_FLAG_EN
  logic        rsp_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  lu_result, rsp_ready,
    output req0_ready, req1_ready, lu_op, lu_a, lu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_err, rsp_zero
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output lu_result, rsp_ready,
    input  req0_ready, req1_ready, lu_op, lu_a, lu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_err, rsp_zero
  );
`else
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  lu_result, rsp_ready,
    output req0_ready, req1_ready, lu_op, lu_a, lu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_err
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output lu_result, rsp_ready,
    input  req0_ready, req1_ready, lu_op, lu_a, lu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_err
  );
`endif
endinterface

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sequencer for the shared 32-bit bitwise
// logic unit. Accepts one operation at a time from two requesters, holds the
// operands on lu_* for SETTLE_CYCLES (legal 1..15) to cover the unit's gate
// delay, then captures lu_result into a response register held until taken.
// Optional feature macro: LU_ZERO_FLAG_EN adds rsp_zero (result == 0, forced
// to 1 for illegal-op responses).
`timescale 1ns/1ps
module logic_unit_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  logic_unit_arbiter_if.slave bus
);

  localparam int          DATA_W      = 32;
  localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Opcodes 6 and 7 have no logic-unit function.
  function automatic logic op_illegal(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_err_q, rsp_err_d;
`ifdef LU_ZERO_FLAG_EN
  logic                rsp_zero_q, rsp_zero_d;
`endif

  logic                grant;
  logic                any_valid;
  logic                ready0, ready1;
  logic                accept;
  logic [2:0]          sel_op;
  logic [DATA_W-1:0]   sel_a, sel_b;

  // Round-robin grant: a lone requester wins; on contention the one that was
  // not granted last time wins.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant     = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req1_valid;
    end
    sel_op = grant ? bus.req1_op : bus.req0_op;
    sel_a  = grant ? bus.req1_a  : bus.req0_a;
    sel_b  = grant ? bus.req1_b  : bus.req0_b;
  end

  // Readies only in IDLE and never during reset; at most one is high.
  assign ready0 = !reset && (state_q == IDLE) && any_valid && !grant;
  assign ready1 = !reset && (state_q == IDLE) && any_valid &&  grant;
  assign accept = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.lu_op      = op_q;
  assign bus.lu_a       = a_q;
  assign bus.lu_b       = b_q;
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
`ifdef LU_ZERO_FLAG_EN
  assign bus.rsp_zero   = rsp_zero_q;
`endif

  // Next-state and register updates for the IDLE -> SETTLE -> DONE sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
`ifdef LU_ZERO_FLAG_EN
    rsp_zero_d   = rsp_zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = grant;
          rsp_id_d     = grant;
          if (op_illegal(sel_op)) begin
            // Illegal op never reaches the unit; operand registers keep
            // their previous contents.
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
`ifdef LU_ZERO_FLAG_EN
            rsp_zero_d   = 1'b1;
`endif
            state_d      = DONE;
          end else begin
            op_d    = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
            cnt_d   = SETTLE_INIT;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = bus.lu_result;
          rsp_err_d    = 1'b0;
`ifdef LU_ZERO_FLAG_EN
          rsp_zero_d   = (bus.lu_result == '0);
`endif
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
`ifdef LU_ZERO_FLAG_EN
      rsp_zero_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
`ifdef LU_ZERO_FLAG_EN
      rsp_zero_q   <= rsp_zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed test of logic_unit_arbiter with a behavioural
// model of the bitwise logic unit. Zero-flag checks compile in when
// LU_ZERO_FLAG_EN is defined.
`timescale 1ns/1ps
module tb_logic_unit_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  logic_unit_arbiter_if bus();

  logic_unit_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural logic unit.
  always_comb begin
    case (bus.lu_op)
      3'd0:    bus.lu_result = ~bus.lu_a;
      3'd1:    bus.lu_result = bus.lu_a & bus.lu_b;
      3'd2:    bus.lu_result = bus.lu_a | bus.lu_b;
      3'd3:    bus.lu_result = bus.lu_a ^ bus.lu_b;
      3'd4:    bus.lu_result = ~(bus.lu_a & bus.lu_b);
      3'd5:    bus.lu_result = ~(bus.lu_a | bus.lu_b);
      default: bus.lu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
    #1;
  endtask

  // Issue one op on requester n, return edges from accept to rsp_valid.
  task automatic issue(input int n, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    int k;
    set_req(n, 1'b1, op, a, b);
    k = 0;
    while (!(n == 0 ? bus.req0_ready : bus.req1_ready) && k < 20) begin
      tick();
      k++;
    end
    chk("issue_ready_wait", 32'(k >= 20), 32'd0);
    tick();
    set_req(n, 1'b0, op, a, b);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  logic [2:0]  op0 [4] = '{3'd1, 3'd2, 3'd4, 3'd3};
  logic [31:0] a0  [4] = '{32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFF0000, 32'hAAAAAAAA};
  logic [31:0] b0  [4] = '{32'hFF00FF00, 32'h000000F0, 32'hFF00FF00, 32'h55555555};
  logic [31:0] r0  [4] = '{32'hF000F000, 32'h0F0F00F0, 32'h00FFFFFF, 32'hFFFFFFFF};
  logic [2:0]  op1 [4] = '{3'd5, 3'd3, 3'd0, 3'd1};
  logic [31:0] a1  [4] = '{32'h0000000F, 32'h12345678, 32'h0000FFFF, 32'h80000001};
  logic [31:0] b1  [4] = '{32'h000000F0, 32'hFFFFFFFF, 32'h12345678, 32'h00000001};
  logic [31:0] r1  [4] = '{32'hFFFFFF00, 32'hEDCBA987, 32'hFFFF0000, 32'h00000001};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    int idx0;
    int idx1;
    logic [31:0] hold_res;

    reset = 1'b1;
    bus.rsp_ready = 1'b0;
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(0, 1'b1, 3'd1, 32'h1, 32'h1);
    repeat (2) tick();
    chk("rst_rdy0",   32'(bus.req0_ready), 32'd0);
    chk("rst_valid",  32'(bus.rsp_valid),  32'd0);
    chk("rst_lu_op",  32'(bus.lu_op),      32'd0);
    chk("rst_lu_a",   bus.lu_a,            32'd0);
    chk("rst_lu_b",   bus.lu_b,            32'd0);
    chk("rst_result", bus.rsp_result,      32'd0);
    chk("rst_id",     32'(bus.rsp_id),     32'd0);
    chk("rst_err",    32'(bus.rsp_err),    32'd0);
`ifdef LU_ZERO_FLAG_EN
    chk("rst_zero",   32'(bus.rsp_zero),   32'd0);
`endif
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_rdy0",  32'(bus.req0_ready), 32'd0);
    chk("idle_rdy1",  32'(bus.req1_ready), 32'd0);
    chk("idle_valid", 32'(bus.rsp_valid),  32'd0);

    // Single legal op: NOT 0x15.
    set_req(0, 1'b1, 3'd0, 32'h00000015, 32'h00000033);
    chk("single_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("single_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    set_req(0, 1'b0, 3'd0, 32'h0, 32'h0);
    chk("single_e0_valid", 32'(bus.rsp_valid), 32'd0);
    chk("single_lu_op",    32'(bus.lu_op),     32'd0);
    chk("single_lu_a",     bus.lu_a,           32'h00000015);
    chk("single_lu_b",     bus.lu_b,           32'h00000033);
    tick();
    chk("single_e1_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("single_e2_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_result",   bus.rsp_result,     32'hFFFFFFEA);
    chk("single_id",       32'(bus.rsp_id),    32'd0);
    chk("single_err",      32'(bus.rsp_err),   32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("single_release", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;

    // Illegal op from req1.
    issue(1, 3'd7, 32'h0000AAAA, 32'h0000BBBB, lat);
    chk("ill_latency", 32'(lat),            32'd0);
    chk("ill_valid",   32'(bus.rsp_valid),  32'd1);
    chk("ill_result",  bus.rsp_result,      32'd0);
    chk("ill_err",     32'(bus.rsp_err),    32'd1);
    chk("ill_id",      32'(bus.rsp_id),     32'd1);
    chk("ill_lu_op",   32'(bus.lu_op),      32'd0);
    chk("ill_lu_a",    bus.lu_a,            32'h00000015);
    chk("ill_lu_b",    bus.lu_b,            32'h00000033);
`ifdef LU_ZERO_FLAG_EN
    chk("ill_zero",    32'(bus.rsp_zero),   32'd1);
`endif
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Backpressure: response held while both requesters wait.
    issue(1, 3'd2, 32'h00000F00, 32'h000000F0, lat);
    chk("bp_latency", 32'(lat),         32'd2);
    chk("bp_result",  bus.rsp_result,   32'h00000FF0);
    chk("bp_id",      32'(bus.rsp_id),  32'd1);
    chk("bp_err",     32'(bus.rsp_err), 32'd0);
    set_req(0, 1'b1, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00);
    set_req(1, 1'b1, 3'd2, 32'h1, 32'h2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid",  32'(bus.rsp_valid),  32'd1);
      chk("bp_hold_result", bus.rsp_result,      32'h00000FF0);
      chk("bp_hold_rdy0",   32'(bus.req0_ready), 32'd0);
      chk("bp_hold_rdy1",   32'(bus.req1_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(bus.rsp_valid),  32'd0);
    chk("bp_rel_rdy0",  32'(bus.req0_ready), 32'd1);
    chk("bp_rel_rdy1",  32'(bus.req1_ready), 32'd0);
    set_req(1, 1'b0, 3'd0, 32'h0, 32'h0);
    set_req(0, 1'b0, 3'd0, 32'h0, 32'h0);
    bus.rsp_ready = 1'b0;

    // Reset in the middle of SETTLE.
    set_req(0, 1'b1, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    set_req(0, 1'b0, 3'd0, 32'h0, 32'h0);
    chk("mid_settle_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_settle_lu_a",  bus.lu_a,           32'hF0F0F0F0);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid",  32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_result", bus.rsp_result,     32'd0);
    chk("mid_rst_id",     32'(bus.rsp_id),    32'd0);
    chk("mid_rst_lu_a",   bus.lu_a,           32'd0);
    chk("mid_rst_lu_op",  32'(bus.lu_op),     32'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_valid", 32'(bus.rsp_valid),  32'd0);
    chk("post_rst_rdy0",  32'(bus.req0_ready), 32'd0);
    chk("post_rst_rdy1",  32'(bus.req1_ready), 32'd0);

    // Contention: both valid, four ops each, strict alternation from req0.
    bus.rsp_ready = 1'b1;
    idx0 = 0;
    idx1 = 0;
    set_req(0, 1'b1, op0[0], a0[0], b0[0]);
    set_req(1, 1'b1, op1[0], a1[0], b1[0]);
    for (int t = 0; t < 8; t++) begin
      k = 0;
      while (!(bus.req0_ready || bus.req1_ready) && k < 20) begin
        tick();
        k++;
      end
      chk("cont_ready_wait", 32'(k >= 20), 32'd0);
      chk("cont_grant", 32'(bus.req1_ready), 32'(t % 2));
      hold_res = (t % 2 == 1) ? r1[t / 2] : r0[t / 2];
      if (bus.req1_ready) begin
        tick();
        idx1++;
        if (idx1 < 4) set_req(1, 1'b1, op1[idx1], a1[idx1], b1[idx1]);
        else          set_req(1, 1'b0, 3'd0, 32'h0, 32'h0);
      end else begin
        tick();
        idx0++;
        if (idx0 < 4) set_req(0, 1'b1, op0[idx0], a0[idx0], b0[idx0]);
        else          set_req(0, 1'b0, 3'd0, 32'h0, 32'h0);
      end
      lat = 0;
      while (!bus.rsp_valid && lat < 40) begin
        tick();
        lat++;
      end
      chk("cont_latency", 32'(lat),         32'd2);
      chk("cont_id",      32'(bus.rsp_id),  32'(t % 2));
      chk("cont_result",  bus.rsp_result,   hold_res);
      chk("cont_err",     32'(bus.rsp_err), 32'd0);
      tick();
    end
    set_req(0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_req(1, 1'b0, 3'd0, 32'h0, 32'h0);

`ifdef LU_ZERO_FLAG_EN
    // Zero flag on captured results.
    bus.rsp_ready = 1'b0;
    issue(0, 3'd3, 32'h12345678, 32'h12345678, lat);
    chk("zf_xor_result", bus.rsp_result,     32'd0);
    chk("zf_xor_zero",   32'(bus.rsp_zero),  32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    issue(1, 3'd2, 32'h00000000, 32'h00000001, lat);
    chk("zf_or_result",  bus.rsp_result,     32'd1);
    chk("zf_or_zero",    32'(bus.rsp_zero),  32'd0);
    bus.rsp_ready = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
